// File: rtl/axi_lite_static_master.sv
// axi_lite_static_master
// Turns single commands into AXI4-Lite transactions, one outstanding at most,
// with a per-phase watchdog that aborts a stuck transaction.
//
// Ports
//   CLK_IN_250, AXI_RESET_N  : clock (rising edge), async active-low reset
//   CMD_*                    : command in (valid/ready, write flag, addr, wdata, wstrb)
//   RSP_*                    : response out (valid/ready, rdata, resp, timeout flag)
//   M_AXI_LITE_aw/w/b/ar/r   : AXI4-Lite master channels
//   dbg_state                : current FSM state (encoding of state_t)
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1. The source holds valid and its payload steady until
// that edge. The only exception is a watchdog abort, which drops the master
// valids. Ready may change freely.
module axi_lite_static_master #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [2:0] PROT           = 3'b000
) (
    input  logic        CLK_IN_250,
    input  logic        AXI_RESET_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    input  logic [3:0]  CMD_WSTRB,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic [1:0]  RSP_RESP,
    output logic        RSP_TIMEOUT,
    output logic        M_AXI_LITE_awvalid,
    input  logic        M_AXI_LITE_awready,
    output logic [31:0] M_AXI_LITE_awaddr,
    output logic [2:0]  M_AXI_LITE_awprot,
    output logic        M_AXI_LITE_wvalid,
    input  logic        M_AXI_LITE_wready,
    output logic [31:0] M_AXI_LITE_wdata,
    output logic [3:0]  M_AXI_LITE_wstrb,
    input  logic        M_AXI_LITE_bvalid,
    output logic        M_AXI_LITE_bready,
    input  logic [1:0]  M_AXI_LITE_bresp,
    output logic        M_AXI_LITE_arvalid,
    input  logic        M_AXI_LITE_arready,
    output logic [31:0] M_AXI_LITE_araddr,
    output logic [2:0]  M_AXI_LITE_arprot,
    input  logic        M_AXI_LITE_rvalid,
    output logic        M_AXI_LITE_rready,
    input  logic [31:0] M_AXI_LITE_rdata,
    input  logic [1:0]  M_AXI_LITE_rresp,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        abort;
    // Low in reset and set on the first edge afterwards; keeps CMD_READY and the
    // drain readies low while reset is held even though the state is IDLE.
    logic        alive;
    logic [15:0] cnt;
    logic        aw_done;
    logic        w_done;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;
    logic        rsp_timeout_q;

    logic aw_ok;
    logic w_ok;
    logic limit_hit;
    logic cmd_fire;
    logic phase_active;

    assign aw_ok        = aw_done | (M_AXI_LITE_awvalid & M_AXI_LITE_awready);
    assign w_ok         = w_done  | (M_AXI_LITE_wvalid  & M_AXI_LITE_wready);
    assign limit_hit    = (cnt == LIMIT);
    assign cmd_fire     = CMD_VALID & CMD_READY;
    assign phase_active = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                          (state == S_RD_REQ) || (state == S_RD_DATA);

    // State register
    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) state <= S_IDLE;
        else              state <= next_state;
    end

    // Next state; a completing handshake is checked before the watchdog so that
    // it wins when both happen in the same cycle.
    always_comb begin
        next_state = state;
        abort      = 1'b0;
        case (state)
            S_IDLE:    if (cmd_fire) next_state = CMD_WRITE ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (aw_ok && w_ok)          next_state = S_WR_RESP;
                       else if (limit_hit) begin next_state = S_RSP; abort = 1'b1; end
            S_WR_RESP: if (M_AXI_LITE_bvalid)      next_state = S_RSP;
                       else if (limit_hit) begin next_state = S_RSP; abort = 1'b1; end
            S_RD_REQ:  if (M_AXI_LITE_arready)     next_state = S_RD_DATA;
                       else if (limit_hit) begin next_state = S_RSP; abort = 1'b1; end
            S_RD_DATA: if (M_AXI_LITE_rvalid)      next_state = S_RSP;
                       else if (limit_hit) begin next_state = S_RSP; abort = 1'b1; end
            S_RSP:     if (RSP_READY)              next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs; bready/rready stay high in IDLE and RSP to swallow late beats from
    // a slave whose transaction was aborted.
    always_comb begin
        CMD_READY          = alive && (state == S_IDLE);
        RSP_VALID          = (state == S_RSP);
        M_AXI_LITE_awvalid = (state == S_WR_REQ) && !aw_done;
        M_AXI_LITE_wvalid  = (state == S_WR_REQ) && !w_done;
        M_AXI_LITE_arvalid = (state == S_RD_REQ);
        M_AXI_LITE_bready  = alive && ((state == S_WR_RESP) || (state == S_IDLE) || (state == S_RSP));
        M_AXI_LITE_rready  = alive && ((state == S_RD_DATA) || (state == S_IDLE) || (state == S_RSP));
    end

    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) begin
            alive         <= 1'b0;
            cnt           <= 16'd0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            rsp_rdata_q   <= 32'd0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            alive <= 1'b1;

            if (next_state != state) cnt <= 16'd0;
            else if (phase_active)   cnt <= cnt + 16'd1;

            if (cmd_fire) begin
                addr_q  <= CMD_ADDR;
                wdata_q <= CMD_WDATA;
                wstrb_q <= CMD_WSTRB;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == S_WR_REQ) begin
                if (M_AXI_LITE_awvalid && M_AXI_LITE_awready) aw_done <= 1'b1;
                if (M_AXI_LITE_wvalid && M_AXI_LITE_wready)   w_done  <= 1'b1;
            end

            if (state != S_RSP && next_state == S_RSP) begin
                if (abort) begin
                    rsp_rdata_q   <= 32'd0;
                    rsp_resp_q    <= 2'b10;
                    rsp_timeout_q <= 1'b1;
                end else if (state == S_RD_DATA) begin
                    rsp_rdata_q   <= M_AXI_LITE_rdata;
                    rsp_resp_q    <= M_AXI_LITE_rresp;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    rsp_rdata_q   <= 32'd0;
                    rsp_resp_q    <= M_AXI_LITE_bresp;
                    rsp_timeout_q <= 1'b0;
                end
            end
        end
    end

    assign M_AXI_LITE_awaddr = addr_q;
    assign M_AXI_LITE_awprot = PROT;
    assign M_AXI_LITE_wdata  = wdata_q;
    assign M_AXI_LITE_wstrb  = wstrb_q;
    assign M_AXI_LITE_araddr = addr_q;
    assign M_AXI_LITE_arprot = PROT;
    assign RSP_RDATA         = rsp_rdata_q;
    assign RSP_RESP          = rsp_resp_q;
    assign RSP_TIMEOUT       = rsp_timeout_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_axi_lite_static_master.sv
// Testbench for axi_lite_static_master: table vectors, hand-written reset and
// stray-beat sequences, and randomized transactions against a timing model.
module tb_axi_lite_static_master;

    localparam int         TO     = 8;
    localparam logic [2:0] PROT_V = 3'b010;
    localparam int         W      = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot, dbg_state;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    axi_lite_static_master #(.TIMEOUT_CYCLES(TO), .PROT(PROT_V)) dut (
        .CLK_IN_250(clk), .AXI_RESET_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_RESP(rsp_resp), .RSP_TIMEOUT(rsp_timeout),
        .M_AXI_LITE_awvalid(m_awvalid), .M_AXI_LITE_awready(m_awready),
        .M_AXI_LITE_awaddr(m_awaddr), .M_AXI_LITE_awprot(m_awprot),
        .M_AXI_LITE_wvalid(m_wvalid), .M_AXI_LITE_wready(m_wready),
        .M_AXI_LITE_wdata(m_wdata), .M_AXI_LITE_wstrb(m_wstrb),
        .M_AXI_LITE_bvalid(m_bvalid), .M_AXI_LITE_bready(m_bready),
        .M_AXI_LITE_bresp(m_bresp),
        .M_AXI_LITE_arvalid(m_arvalid), .M_AXI_LITE_arready(m_arready),
        .M_AXI_LITE_araddr(m_araddr), .M_AXI_LITE_arprot(m_arprot),
        .M_AXI_LITE_rvalid(m_rvalid), .M_AXI_LITE_rready(m_rready),
        .M_AXI_LITE_rdata(m_rdata), .M_AXI_LITE_rresp(m_rresp),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: a phase succeeds if its handshake lands within TO cycles of
    // entering it; the write request phase ends when the later of aw/w lands.
    function automatic void model(input logic wr, input int da, input int dw, input int dr,
                                  input logic [1:0] sresp, input logic [31:0] sdata,
                                  output logic [1:0] er, output logic eto, output logic [31:0] ed);
        int  req_lat;
        logic ok;
        req_lat = (wr && dw > da) ? dw : da;
        ok = (req_lat <= TO - 1) && (dr <= TO - 1);
        er  = ok ? sresp : 2'b10;
        eto = !ok;
        ed  = (ok && !wr) ? sdata : 32'd0;
    endfunction

    function automatic int min_lim(input int d);
        return (d < TO - 1) ? d : TO - 1;
    endfunction

    task automatic idle_slave();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    endtask

    // One transaction. Slave raises each ready after d cycles of valid and the
    // response valid d cycles after the request phase completes, holding it until
    // accepted (which also exercises draining after an abort).
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int da, input int dw, input int dr,
                           input logic [1:0] sresp, input logic [31:0] sdata, input int rsp_wait,
                           input logic [1:0] exp_resp, input logic exp_to, input logic [31:0] exp_rdata);
        int a_cnt, w_cnt, r_cnt, a_high, w_high, hold, guard;
        logic a_hs, w_hs, x_hs, rsp_hs, a_done, w_done, x_done, rsp_done, rsp_seen, finished;
        logic rdy_a, rdy_w, xv;
        logic addr_err, data_err, relaunch_err, hold_err, dup_err, busy_err;
        logic [W-1:0] cap, exp_v;
        a_cnt = 0; w_cnt = 0; r_cnt = 0; a_high = 0; w_high = 0; hold = 0; guard = 0;
        a_hs = 0; w_hs = 0; x_hs = 0; rsp_hs = 0; a_done = 0; w_done = !wr; x_done = 0;
        rsp_done = 0; rsp_seen = 0; finished = 0;
        addr_err = 0; data_err = 0; relaunch_err = 0; hold_err = 0; dup_err = 0; busy_err = 0;
        cap = '0;
        exp_q.push_back({exp_resp, exp_to, exp_rdata});

        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        check({name, "_accept"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (a_hs) a_done = 1;
            if (w_hs) w_done = 1;
            if (x_hs) x_done = 1;
            if (rsp_hs) rsp_done = 1;
            a_hs = 0; w_hs = 0; x_hs = 0; rsp_hs = 0;
            if (rsp_done && (x_done || !(a_done && w_done))) begin
                finished = 1;
            end else begin
                rdy_a = 0;
                if (wr ? m_awvalid : m_arvalid) begin
                    if (a_done) relaunch_err = 1;
                    a_high++;
                    if ((wr ? m_awaddr : m_araddr) !== addr || (wr ? m_awprot : m_arprot) !== PROT_V)
                        addr_err = 1;
                    rdy_a = (a_cnt == da);
                    a_cnt++;
                    a_hs = rdy_a;
                end
                if (wr) m_awready = rdy_a; else m_arready = rdy_a;
                rdy_w = 0;
                if (wr && m_wvalid) begin
                    if (w_done) relaunch_err = 1;
                    w_high++;
                    if (m_wdata !== data || m_wstrb !== strb) data_err = 1;
                    rdy_w = (w_cnt == dw);
                    w_cnt++;
                    w_hs = rdy_w;
                end
                m_wready = rdy_w;
                xv = 0;
                if (a_done && w_done && !x_done) begin
                    xv = (r_cnt >= dr);
                    r_cnt++;
                    x_hs = xv && (wr ? m_bready : m_rready);
                end
                if (wr) begin
                    m_bvalid = xv; m_bresp = xv ? sresp : 2'b00;
                end else begin
                    m_rvalid = xv; m_rresp = xv ? sresp : 2'b00; m_rdata = xv ? sdata : 32'd0;
                end
                rsp_ready = 0;
                if (rsp_valid) begin
                    if (rsp_done) dup_err = 1;
                    else if (!rsp_seen) begin
                        rsp_seen = 1;
                        cap = {rsp_resp, rsp_timeout, rsp_rdata};
                        if (exp_q.size() == 0) check({name, "_sb_empty"}, 1, 0);
                        else begin
                            exp_v = exp_q.pop_front();
                            check({name, "_resp"}, cap[34:33], exp_v[34:33]);
                            check({name, "_timeout"}, cap[32], exp_v[32]);
                            check({name, "_rdata"}, cap[31:0], exp_v[31:0]);
                        end
                    end else if ({rsp_resp, rsp_timeout, rsp_rdata} !== cap) hold_err = 1;
                    if (!rsp_done) begin
                        rsp_ready = (hold >= rsp_wait);
                        hold++;
                        rsp_hs = rsp_ready;
                    end
                end
                if (!rsp_done && cmd_ready) busy_err = 1;
                @(negedge clk);
            end
        end
        idle_slave();
        rsp_ready = 0;
        check({name, "_complete"}, finished, 1);
        check({name, "_a_cycles"}, a_high, min_lim(da) + 1);
        if (wr) check({name, "_w_cycles"}, w_high, min_lim(dw) + 1);
        check({name, "_addr_prot"}, addr_err, 0);
        check({name, "_wdata_strb"}, data_err, 0);
        check({name, "_valid_after_hs"}, relaunch_err, 0);
        check({name, "_rsp_stable"}, hold_err, 0);
        check({name, "_rsp_once"}, dup_err, 0);
        check({name, "_cmd_ready_busy"}, busy_err, 0);
        check({name, "_cmd_ready_after"}, cmd_ready, 1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          da, dw, dr;
        logic [1:0]  sresp;
        logic [31:0] sdata;
        int          rsp_wait;
        logic [1:0]  exp_resp;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int da, input int dw, input int dr,
                                input logic [1:0] sresp, input logic [31:0] sdata, input int rw,
                                input logic [1:0] er, input logic eto, input logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.da = da; v.dw = dw; v.dr = dr; v.sresp = sresp; v.sdata = sdata; v.rsp_wait = rw;
        v.exp_resp = er; v.exp_to = eto; v.exp_rdata = ed;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        logic [1:0]  er;
        logic        eto;
        logic [31:0] ed;
        logic        stray_err;
        int          guard;

        // wr, addr, data, strb, da, dw, dr, sresp, sdata, rsp_wait, exp_resp, exp_to, exp_rdata
        vecs[0]  = mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 2, 1, 2'b00, 0, 0, 2'b00, 0, 32'h0);
        vecs[1]  = mk(0, 32'h24,  0, 4'h0, 0, 0, 5, 2'b00, 32'h12345678, 3, 2'b00, 0, 32'h12345678);
        vecs[2]  = mk(1, 32'h100, 32'hCAFEF00D, 4'h5, 0, 0, 0, 2'b11, 0, 2, 2'b11, 0, 32'h0);
        vecs[3]  = mk(1, 32'h200, 32'h00000001, 4'h3, 4, 0, 2, 2'b10, 0, 0, 2'b10, 0, 32'h0);
        vecs[4]  = mk(0, 32'h300, 0, 4'h0, 2, 0, 0, 2'b11, 32'hAAAA5555, 1, 2'b11, 0, 32'hAAAA5555);
        vecs[5]  = mk(1, 32'h404, 32'h0BADF00D, 4'h8, 7, 7, 7, 2'b00, 0, 0, 2'b00, 0, 32'h0);
        vecs[6]  = mk(1, 32'h408, 32'h11112222, 4'hF, 8, 0, 0, 2'b00, 0, 0, 2'b10, 1, 32'h0);
        vecs[7]  = mk(0, 32'h40C, 0, 4'h0, 0, 0, 9, 2'b00, 32'h00000055, 3, 2'b10, 1, 32'h0);
        vecs[8]  = mk(0, 32'h410, 0, 4'h0, 7, 0, 7, 2'b01, 32'h87654321, 0, 2'b01, 0, 32'h87654321);
        vecs[9]  = mk(1, 32'h414, 32'h33334444, 4'hC, 0, 0, 8, 2'b00, 0, 1, 2'b10, 1, 32'h0);
        vecs[10] = mk(0, 32'h500, 0, 4'h0, 100, 0, 0, 2'b00, 32'h99, 0, 2'b10, 1, 32'h0);

        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        idle_slave();

        // Reset state
        #3;
        check("reset_outputs",
              {cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
               rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
        @(negedge clk); @(negedge clk);
        check("reset_held_cmd_ready", cmd_ready, 0);
        rst_n = 1;
        @(negedge clk);
        check("post_reset_ready", {cmd_ready, m_bready, m_rready}, 3'b111);
        check("post_reset_no_rsp", rsp_valid, 0);

        for (int i = 0; i < 11; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                    vecs[i].da, vecs[i].dw, vecs[i].dr, vecs[i].sresp, vecs[i].sdata,
                    vecs[i].rsp_wait, vecs[i].exp_resp, vecs[i].exp_to, vecs[i].exp_rdata);

        // Late read beat arriving in IDLE after the aborted vec10 is swallowed
        @(negedge clk);
        check("stray_rready", m_rready, 1);
        m_rvalid = 1; m_rdata = 32'hBAD0BAD0; m_rresp = 2'b11;
        stray_err = 0;
        repeat (5) begin
            @(negedge clk);
            m_rvalid = 0;
            if (rsp_valid) stray_err = 1;
        end
        check("stray_not_reported", stray_err, 0);
        check("stray_cmd_ready", cmd_ready, 1);

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            logic        wr;
            int          da, dw, dr, rw;
            logic [1:0]  sresp;
            logic [31:0] sdata, addr, data;
            logic [3:0]  strb;
            wr = 1'($urandom_range(0, 1));
            da = $urandom_range(0, 9); dw = $urandom_range(0, 9); dr = $urandom_range(0, 9);
            rw = $urandom_range(0, 3);
            sresp = 2'($urandom_range(0, 3));
            sdata = $urandom; addr = $urandom & 32'hFFFF_FFFC; data = $urandom;
            strb = 4'($urandom_range(0, 15));
            model(wr, da, dw, dr, sresp, sdata, er, eto, ed);
            run_txn($sformatf("rnd%0d", i), wr, addr, data, strb, da, dw, dr, sresp, sdata, rw,
                    er, eto, ed);
        end

        // Reset asserted while waiting for read data
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid = 0;
        check("mid_rst_arvalid", m_arvalid, 1);
        m_arready = 1;
        @(negedge clk);
        m_arready = 0;
        check("mid_rst_in_rd_data", {m_arvalid, m_rready, rsp_valid}, 3'b010);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_outputs",
              {cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
               rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        m_rvalid = 1; m_rdata = 32'h5A5A5A5A; m_rresp = 2'b00;
        stray_err = 0;
        repeat (8) begin
            @(negedge clk);
            m_rvalid = 0;
            if (rsp_valid) stray_err = 1;
        end
        check("mid_rst_no_rsp", stray_err, 0);
        check("mid_rst_ready", {cmd_ready, m_bready, m_rready}, 3'b111);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_static_master.md
AXI_LITE_STATIC_MASTER -- requirements
Module: axi_lite_static_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed per AXI phase before abort; legal range 2..65535.
REQ-002 Parameter PROT, default 3'b000: constant driven on awprot/arprot.
REQ-003 CLK_IN_250  in  1  sole clock; all logic rising-edge.
REQ-004 AXI_RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 CMD_VALID / CMD_READY  in/out  1/1  command handshake.
REQ-006 CMD_WRITE  in  1  1=write, 0=read.
REQ-007 CMD_ADDR  in  32  byte address.
REQ-008 CMD_WDATA / CMD_WSTRB  in  32/4  write data and strobes.
REQ-009 RSP_VALID / RSP_READY  out/in  1/1  response handshake.
REQ-010 RSP_RDATA  out  32  read data (0 for writes).
REQ-011 RSP_RESP  out  2  AXI response code.
REQ-012 RSP_TIMEOUT  out  1  transaction aborted by timeout.
REQ-013 M_AXI_LITE_aw{valid out 1, ready in 1, addr out 32, prot out 3}: write address channel.
REQ-014 M_AXI_LITE_w{valid out 1, ready in 1, data out 32, strb out 4}: write data channel.
REQ-015 M_AXI_LITE_b{valid in 1, ready out 1, resp in 2}: write response channel.
REQ-016 M_AXI_LITE_ar{valid out 1, ready in 1, addr out 32, prot out 3}: read address channel.
REQ-017 M_AXI_LITE_r{valid in 1, ready out 1, data in 32, resp in 2}: read data channel.

Function
REQ-018 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one outstanding transaction maximum.
REQ-019 CMD_READY = 1 only in IDLE; command accepted on CMD_VALID&CMD_READY; addr/wdata/wstrb registered at acceptance.
REQ-020 Accepted write -> WR_REQ next cycle with awvalid=wvalid=1 together.
REQ-021 In WR_REQ, awvalid and wvalid each drop the cycle after their own handshake; either order or same-cycle is legal.
REQ-022 WR_REQ -> WR_RESP once both handshakes done; bready=1 in WR_RESP; bvalid captures bresp -> RSP.
REQ-023 Accepted read -> RD_REQ with arvalid=1; arready -> RD_DATA with rready=1; rvalid captures rdata/rresp -> RSP.
REQ-024 Valids never deassert before handshake unless timeout aborts; addr/data/strb stable while valid.
REQ-025 RSP: RSP_VALID=1, outputs stable until RSP_READY; RSP_VALID&RSP_READY -> IDLE; minimum IDLE dwell one cycle.
REQ-026 Timeout counter, 16 bits, clears on every state entry, increments each cycle in WR_REQ, WR_RESP, RD_REQ, RD_DATA; reaching TIMEOUT_CYCLES-1 aborts.
REQ-027 Abort: all AXI valids deasserted next cycle, RSP with RSP_RESP=2'b10, RSP_TIMEOUT=1, RSP_RDATA=0.
REQ-028 After abort, stray bvalid/rvalid in IDLE or RSP accepted (bready/rready=1 there) and discarded, not reported.
REQ-029 Handshake in the same cycle the counter hits limit: handshake wins, no timeout.
REQ-030 Normal response: RSP_TIMEOUT=0, RSP_RESP passes AXI resp unchanged (SLVERR/DECERR forwarded).
REQ-031 awprot/arprot = PROT always; awaddr/araddr = registered CMD_ADDR.

Reset
REQ-032 AXI_RESET_N low: state IDLE, all valids 0, bready=rready=0, CMD_READY=0, RSP_VALID=0, RSP_* data 0, counter 0, asynchronously.
REQ-033 First rising edge after deassertion: CMD_READY=1, bready=rready=1 (drain); reset mid-transaction abandons it without any response.

Verification
REQ-034 Write 0x10, data 0xDEADBEEF, strb 0xF; awready 2 cycles before wready; bresp 00 -> RSP_RESP=00, RSP_TIMEOUT=0, awaddr=0x10, wdata unchanged.
REQ-035 Read 0x24; arready immediate, rvalid after 5 cycles data 0x12345678 resp 00 -> RSP_RDATA=0x12345678; RSP held 3 cycles under RSP_READY=0.
REQ-036 TIMEOUT_CYCLES=8, read, arready never -> arvalid drops after 8 cycles, RSP_RESP=10, RSP_TIMEOUT=1; late rvalid discarded.
REQ-037 Write with bresp=11 -> RSP_RESP=11, RSP_TIMEOUT=0; back-to-back command accepted only after RSP handshake.
REQ-038 AXI_RESET_N asserted during RD_DATA -> all outputs at reset values immediately; no RSP_VALID after release.
